local_history_nbit_predictor: RTL and testbench

//  Per-PC local-history branch direction predictor with N-bit saturating counters.

---
 rtl/local_history_nbit_predictor_pkg.sv | 20 ++
 rtl/local_history_nbit_predictor_sat_counter_update.sv | 19 +
 rtl/local_history_nbit_predictor.sv | 156 +++++++++++++++
 tb/tb_local_history_nbit_predictor.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/local_history_nbit_predictor_pkg.sv
// Shared types for the local-history branch predictor: fetch address, resolved-branch
// record and the table-clear FSM states.
package local_history_nbit_predictor_pkg;

   localparam int unsigned WIDTH_ADDR = 32;

   typedef logic [WIDTH_ADDR-1:0] Addr;

   typedef struct packed {
      logic valid;
      Addr  pc;
      logic taken;
   } BrInfo;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } lhp_state_e;

endpackage

// File: rtl/local_history_nbit_predictor_sat_counter_update.sv
// Next value of a WIDTH_CNT-bit saturating direction counter; holds at 0 and at all-ones.
module local_history_nbit_predictor_sat_counter_update #(
   parameter int unsigned WIDTH_CNT = 2
) (
   input  logic [WIDTH_CNT-1:0] i_cnt,
   input  logic                 i_taken,
   output logic [WIDTH_CNT-1:0] o_cnt_c
);

   always_comb begin
      o_cnt_c = i_cnt;
      if (i_taken && (i_cnt != '1)) begin
         o_cnt_c = i_cnt + WIDTH_CNT'(1);
      end else if (!i_taken && (i_cnt != '0)) begin
         o_cnt_c = i_cnt - WIDTH_CNT'(1);
      end
   end

endmodule

// File: rtl/local_history_nbit_predictor.sv
// Per-PC local-history direction predictor with N-bit saturating counters and a table-clear sweep.
// Optional LHP_STATS_EN adds update / misprediction counters on o_stat_updates / o_stat_mispred.
module local_history_nbit_predictor
   import local_history_nbit_predictor_pkg::*;
#(
   parameter int unsigned WIDTH_PC   = 5,
   parameter int unsigned WIDTH_HIST = 10,
   parameter int unsigned WIDTH_CNT  = 2,
   parameter int unsigned HASH_XOR   = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  Addr         i_pc,
   output logic        o_pred_taken,
   output logic        o_pred_strong,
   output logic        o_ready,
   input  logic        i_clear_req,
   input  BrInfo       i_brinfo
`ifdef LHP_STATS_EN
   ,
   output logic [31:0] o_stat_updates,
   output logic [31:0] o_stat_mispred
`endif
);

   localparam int unsigned SIZE_PC    = 2 ** WIDTH_PC;
   localparam int unsigned WIDTH_PHTI = (HASH_XOR != 0) ? WIDTH_HIST : (WIDTH_HIST + WIDTH_PC);
   localparam int unsigned SIZE_PHT   = 2 ** WIDTH_PHTI;
   localparam int unsigned CNT_MAX    = (2 ** WIDTH_CNT) - 1;
   localparam int unsigned CNT_INIT   = (2 ** (WIDTH_CNT - 1)) - 1;

   lhp_state_e                r_state;
   logic [WIDTH_PHTI-1:0]     r_clr_idx;
   logic                      r_ready;
   logic [WIDTH_HIST-1:0]     r_hist [SIZE_PC];
   logic [WIDTH_CNT-1:0]      r_cnt  [SIZE_PHT];

   logic [WIDTH_PC-1:0]       w_p_pcidx;
   logic [WIDTH_HIST-1:0]     w_p_hist;
   logic [WIDTH_PHTI-1:0]     w_p_phti;
   logic [WIDTH_CNT-1:0]      w_p_cnt;
   logic [WIDTH_PC-1:0]       w_u_pcidx;
   logic [WIDTH_HIST-1:0]     w_u_hist;
   logic [WIDTH_PHTI-1:0]     w_u_phti;
   logic [WIDTH_CNT-1:0]      w_u_cnt;
   logic [WIDTH_CNT-1:0]      w_u_cnt_next;
   logic                      w_upd;
   logic                      w_clr_hist;
   logic                      w_unused;

   // PHT index: concatenation, or XOR fold when HASH_XOR is set
   function automatic logic [WIDTH_PHTI-1:0] f_phti(input logic [WIDTH_HIST-1:0] h,
                                                    input logic [WIDTH_PC-1:0]   p);
      if (HASH_XOR != 0) begin
         f_phti = WIDTH_PHTI'(h ^ WIDTH_HIST'(p));
      end else begin
         f_phti = WIDTH_PHTI'({h, p});
      end
   endfunction

   assign w_p_pcidx = i_pc[WIDTH_PC+1:2];
   assign w_p_hist  = r_hist[w_p_pcidx];
   assign w_p_phti  = f_phti(w_p_hist, w_p_pcidx);
   assign w_p_cnt   = r_cnt[w_p_phti];

   assign w_u_pcidx = i_brinfo.pc[WIDTH_PC+1:2];
   assign w_u_hist  = r_hist[w_u_pcidx];
   assign w_u_phti  = f_phti(w_u_hist, w_u_pcidx);
   assign w_u_cnt   = r_cnt[w_u_phti];
   assign w_upd     = (r_state == RUN) && i_brinfo.valid;

   assign w_clr_hist = ({1'b0, r_clr_idx} < (WIDTH_PHTI+1)'(SIZE_PC));
   assign w_unused   = ^{i_pc, i_brinfo.pc};

   assign o_ready       = r_ready;
   assign o_pred_taken  = r_ready & w_p_cnt[WIDTH_CNT-1];
   assign o_pred_strong = r_ready & ((w_p_cnt == '0) || (w_p_cnt == WIDTH_CNT'(CNT_MAX)));

   local_history_nbit_predictor_sat_counter_update #(
      .WIDTH_CNT (WIDTH_CNT)
   ) u_sat (
      .i_cnt   (w_u_cnt),
      .i_taken (i_brinfo.taken),
      .o_cnt_c (w_u_cnt_next)
   );

   // Clear sweep walks every PHT index once, then hands over to RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= CLEAR;
         r_clr_idx <= '0;
         r_ready   <= 1'b0;
      end else begin
         case (r_state)
            CLEAR: begin
               if (i_clear_req) begin
                  r_clr_idx <= '0;
               end else if (&r_clr_idx) begin
                  r_state   <= RUN;
                  r_ready   <= 1'b1;
                  r_clr_idx <= '0;
               end else begin
                  r_clr_idx <= r_clr_idx + WIDTH_PHTI'(1);
               end
            end
            RUN: begin
               if (i_clear_req) begin
                  r_state   <= CLEAR;
                  r_ready   <= 1'b0;
                  r_clr_idx <= '0;
               end
            end
            default: begin
               r_state   <= CLEAR;
               r_ready   <= 1'b0;
               r_clr_idx <= '0;
            end
         endcase
      end
   end

   // Table storage is not reset; the sweep initialises it
   always_ff @(posedge clk) begin
      if (r_state == CLEAR) begin
         r_cnt[r_clr_idx] <= WIDTH_CNT'(CNT_INIT);
         if (w_clr_hist) begin
            r_hist[r_clr_idx[WIDTH_PC-1:0]] <= '0;
         end
      end else if (i_brinfo.valid) begin
         r_cnt[w_u_phti]   <= w_u_cnt_next;
         r_hist[w_u_pcidx] <= {w_u_hist[WIDTH_HIST-2:0], i_brinfo.taken};
      end
   end

`ifdef LHP_STATS_EN
   logic [31:0] r_stat_updates;
   logic [31:0] r_stat_mispred;

   // Statistics survive clear_req; only rst_n zeroes them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stat_updates <= '0;
         r_stat_mispred <= '0;
      end else if (w_upd) begin
         r_stat_updates <= r_stat_updates + 32'(1);
         if (w_u_cnt[WIDTH_CNT-1] != i_brinfo.taken) begin
            r_stat_mispred <= r_stat_mispred + 32'(1);
         end
      end
   end

   assign o_stat_updates = r_stat_updates;
   assign o_stat_mispred = r_stat_mispred;
`endif

endmodule

// File: tb/tb_local_history_nbit_predictor.sv
// Randomised bench for local_history_nbit_predictor: two configurations (concatenated index
// with 2-bit counters, XOR index with 3-bit counters) checked every cycle against a table model.
module tb_local_history_nbit_predictor;
   import local_history_nbit_predictor_pkg::*;

   localparam int unsigned WH0 = 5, WP0 = 3, WC0 = 2, HX0 = 0;
   localparam int unsigned WH1 = 8, WP1 = 4, WC1 = 3, HX1 = 1;

   logic  clk = 1'b0;
   logic  rst_n;
   Addr   pc;
   logic  clear_req;
   BrInfo bi;
   logic [1:0] w_taken, w_strong, w_ready;
`ifdef LHP_STATS_EN
   logic [31:0] w_upd [2];
   logic [31:0] w_mis [2];
`endif

   always #5 clk = ~clk;

   local_history_nbit_predictor #(
      .WIDTH_PC(WP0), .WIDTH_HIST(WH0), .WIDTH_CNT(WC0), .HASH_XOR(HX0)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_pc(pc),
      .o_pred_taken(w_taken[0]), .o_pred_strong(w_strong[0]), .o_ready(w_ready[0]),
      .i_clear_req(clear_req), .i_brinfo(bi)
`ifdef LHP_STATS_EN
      , .o_stat_updates(w_upd[0]), .o_stat_mispred(w_mis[0])
`endif
   );

   local_history_nbit_predictor #(
      .WIDTH_PC(WP1), .WIDTH_HIST(WH1), .WIDTH_CNT(WC1), .HASH_XOR(HX1)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_pc(pc),
      .o_pred_taken(w_taken[1]), .o_pred_strong(w_strong[1]), .o_ready(w_ready[1]),
      .i_clear_req(clear_req), .i_brinfo(bi)
`ifdef LHP_STATS_EN
      , .o_stat_updates(w_upd[1]), .o_stat_mispred(w_mis[1])
`endif
   );

   // Reference model: plain arrays of history values and counter values per configuration
   int unsigned m_hist [2][16];
   int unsigned m_cnt  [2][256];
   bit          m_ready [2];
   int          m_left  [2];
   int unsigned m_upd   [2];
   int unsigned m_mis   [2];
   int          n_checks = 0;
   int          n_errors = 0;

   function automatic int unsigned f_wh(int d); return (d == 0) ? WH0 : WH1; endfunction
   function automatic int unsigned f_wp(int d); return (d == 0) ? WP0 : WP1; endfunction
   function automatic int unsigned f_wc(int d); return (d == 0) ? WC0 : WC1; endfunction
   function automatic int unsigned f_hx(int d); return (d == 0) ? HX0 : HX1; endfunction
   function automatic int unsigned f_size_pc(int d); return 1 << f_wp(d); endfunction
   function automatic int unsigned f_size_pht(int d);
      return (f_hx(d) != 0) ? (1 << f_wh(d)) : (1 << (f_wh(d) + f_wp(d)));
   endfunction
   function automatic int unsigned f_cmax(int d); return (1 << f_wc(d)) - 1; endfunction
   function automatic int unsigned f_half(int d); return 1 << (f_wc(d) - 1); endfunction
   function automatic int unsigned f_pcidx(int d, Addr a);
      return (a >> 2) & (f_size_pc(d) - 1);
   endfunction
   function automatic int unsigned f_idx(int d, int unsigned h, int unsigned p);
      return (f_hx(d) != 0) ? (h ^ p) : ((h << f_wp(d)) | p);
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic m_reset(input int d);
      m_ready[d] = 1'b0;
      m_left[d]  = f_size_pht(d);
      m_upd[d]   = 0;
      m_mis[d]   = 0;
   endtask

   task automatic m_posedge(input int d);
      int unsigned p, h, ix, c;
      if (!rst_n) return;
      if (m_ready[d]) begin
         if (bi.valid) begin
            p  = f_pcidx(d, bi.pc);
            h  = m_hist[d][p];
            ix = f_idx(d, h, p);
            c  = m_cnt[d][ix];
            m_upd[d]++;
            if (((c >> (f_wc(d) - 1)) & 1) != int'(bi.taken)) m_mis[d]++;
            if (bi.taken) m_cnt[d][ix] = (c == f_cmax(d)) ? c : c + 1;
            else          m_cnt[d][ix] = (c == 0) ? 0 : c - 1;
            m_hist[d][p] = ((h << 1) | int'(bi.taken)) & ((1 << f_wh(d)) - 1);
         end
         if (clear_req) begin
            m_ready[d] = 1'b0;
            m_left[d]  = f_size_pht(d);
         end
      end else if (clear_req) begin
         m_left[d] = f_size_pht(d);
      end else begin
         m_left[d]--;
         if (m_left[d] == 0) begin
            for (int i = 0; i < 256; i++) m_cnt[d][i] = f_half(d) - 1;
            for (int i = 0; i < 16; i++) m_hist[d][i] = 0;
            m_ready[d] = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      int unsigned p, c;
      bit et, es;
      for (int d = 0; d < 2; d++) begin
         p  = f_pcidx(d, pc);
         c  = m_cnt[d][f_idx(d, m_hist[d][p], p)];
         et = m_ready[d] && (c >= f_half(d));
         es = m_ready[d] && ((c == 0) || (c == f_cmax(d)));
         chk($sformatf("dut%0d ready", d), int'(w_ready[d]), int'(m_ready[d]));
         chk($sformatf("dut%0d pred_taken pc=%0h", d, pc), int'(w_taken[d]), int'(et));
         chk($sformatf("dut%0d pred_strong pc=%0h", d, pc), int'(w_strong[d]), int'(es));
`ifdef LHP_STATS_EN
         chk($sformatf("dut%0d stat_updates", d), int'(w_upd[d]), int'(m_upd[d]));
         chk($sformatf("dut%0d stat_mispred", d), int'(w_mis[d]), int'(m_mis[d]));
`endif
      end
   endtask

   // One clock: drive after negedge, compare before posedge, advance model at posedge
   task automatic step(input bit v, input Addr bpc, input bit t, input Addr ppc, input bit clr);
      pc        = ppc;
      bi.valid  = v;
      bi.pc     = bpc;
      bi.taken  = t;
      clear_req = clr;
      if (!rst_n) begin
         m_reset(0);
         m_reset(1);
      end
      #2;
      check_outputs();
      @(posedge clk);
      m_posedge(0);
      m_posedge(1);
      @(negedge clk);
   endtask

   function automatic Addr pick_pc();
      case ($urandom % 5)
         0: return 32'h40;
         1: return 32'h44;
         2: return 32'h100;
         3: return 32'h7C;
         default: return Addr'($urandom);
      endcase
   endfunction

   task automatic wait_ready(input bit noisy, output int n0, output int n1);
      n0 = -1;
      n1 = -1;
      for (int i = 1; i <= 2000; i++) begin
         if (noisy) step(1'b1, pick_pc(), 1'($urandom), pick_pc(), 1'b0);
         else       step(1'b0, 32'h0, 1'b0, 32'h40, 1'b0);
         if (w_ready[0] && n0 < 0) n0 = i;
         if (w_ready[1] && n1 < 0) n1 = i;
         if (n0 >= 0 && n1 >= 0) break;
      end
   endtask

   task automatic probe(input Addr a);
      pc = a;
      #1;
   endtask

   initial begin
      int n0, n1;
`ifdef LHP_STATS_EN
      int unsigned mis_mark [2];
`endif
      rst_n     = 1'b0;
      pc        = '0;
      bi        = '0;
      clear_req = 1'b0;
      repeat (3) step(1'b0, 32'h0, 1'b0, 32'h40, 1'b0);
      chk("ready in reset d0", int'(w_ready[0]), 0);

      // Power-up sweep: 256 PHT entries in both configurations
      rst_n = 1'b1;
      wait_ready(1'b0, n0, n1);
      chk("sweep length d0", n0, 256);
      chk("sweep length d1", n1, 256);
      probe(32'h40);
      chk("init taken d0", int'(w_taken[0]), 0);
      chk("init strong d0", int'(w_strong[0]), 0);
      chk("init taken d1", int'(w_taken[1]), 0);
      chk("init strong d1", int'(w_strong[1]), 0);

      // dut0: T then five N returns history to 0; counter at {hist=0,pc} goes 1->2->3->3
      for (int r = 1; r <= 3; r++) begin
         step(1'b1, 32'h40, 1'b1, 32'h40, 1'b0);
         repeat (5) step(1'b1, 32'h40, 1'b0, 32'h40, 1'b0);
         probe(32'h40);
         chk($sformatf("sat taken d0 r%0d", r), int'(w_taken[0]), 1);
         chk($sformatf("sat strong d0 r%0d", r), int'(w_strong[0]), (r >= 2) ? 1 : 0);
      end

      // clear_req in RUN drops ready next cycle and wipes training
      step(1'b0, 32'h0, 1'b0, 32'h40, 1'b1);
      chk("clear ready d0", int'(w_ready[0]), 0);
      chk("clear ready d1", int'(w_ready[1]), 0);
      wait_ready(1'b0, n0, n1);
      chk("clear sweep d0", n0, 256);
      probe(32'h40);
      chk("post-clear taken d0", int'(w_taken[0]), 0);
      chk("post-clear strong d0", int'(w_strong[0]), 0);

      // dut1 (3-bit, XOR): T then eight N at pc 0x44 -> counter 3->4..7, saturating at 7
      for (int r = 1; r <= 5; r++) begin
         step(1'b1, 32'h44, 1'b1, 32'h44, 1'b0);
         repeat (8) step(1'b1, 32'h44, 1'b0, 32'h44, 1'b0);
         probe(32'h44);
         chk($sformatf("sat taken d1 r%0d", r), int'(w_taken[1]), 1);
         chk($sformatf("sat strong d1 r%0d", r), int'(w_strong[1]), (r >= 4) ? 1 : 0);
      end

      // Alternating T,N at one PC is learned perfectly after warm-up
      for (int i = 0; i < 64; i++) begin
`ifdef LHP_STATS_EN
         if (i == 40) begin
            mis_mark[0] = w_mis[0];
            mis_mark[1] = w_mis[1];
         end
`endif
         for (int ph = 0; ph < 2; ph++) begin
            probe(32'h100);
            if (i >= 40) begin
               chk("TN accuracy d0", int'(w_taken[0]), (ph == 0) ? 1 : 0);
               chk("TN accuracy d1", int'(w_taken[1]), (ph == 0) ? 1 : 0);
            end
            step(1'b1, 32'h100, (ph == 0), 32'h100, 1'b0);
         end
      end
`ifdef LHP_STATS_EN
      chk("TN mispred frozen d0", int'(w_mis[0]), int'(mis_mark[0]));
      chk("TN mispred frozen d1", int'(w_mis[1]), int'(mis_mark[1]));
`endif

      // Reset pulse at clr_idx=100 restarts the full sweep; updates during CLEAR are dropped
      step(1'b0, 32'h0, 1'b0, 32'h40, 1'b1);
      repeat (100) step(1'b0, 32'h0, 1'b0, 32'h40, 1'b0);
      rst_n = 1'b0;
      step(1'b1, 32'h40, 1'b1, 32'h40, 1'b0);
      rst_n = 1'b1;
      wait_ready(1'b1, n0, n1);
      chk("restart sweep d0", n0, 256);
      chk("restart sweep d1", n1, 256);
`ifdef LHP_STATS_EN
      chk("no stats in clear d0", int'(w_upd[0]), 0);
      chk("no stats in clear d1", int'(w_upd[1]), 0);
`endif

      // Random traffic with occasional clear requests
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 10) < 6, pick_pc(), 1'($urandom), pick_pc(), ($urandom % 600) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
